reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning number of architectural registers; power of two, >=4.
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports, >=1.
REQ-004 SHALL derive local AW = clog2(NREG), meaning address width.
REQ-005 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port wr0_en / wr0_addr / wr0_data  input  1 / AW / XLEN  write port 0.
REQ-008 SHALL have port wr1_en / wr1_addr / wr1_data  input  1 / AW / XLEN  write port 1.
REQ-009 SHALL have port rd_addr  input  NRP*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-010 SHALL have port rd_data  output  NRP*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
REQ-011 SHALL have port rd_busy  output  NRP  per-read-port pending-write flag.
REQ-012 SHALL have port sb_set_en / sb_set_addr  input  1 / AW  mark a register as pending, i.e. an issued producer has not yet written it.
REQ-013 SHALL have port ready  output  1  high once the initialisation sweep has completed.

Function
REQ-014 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT with clear counter = 0.
REQ-015 In INIT, SHALL clear register[counter] to 0 and its busy bit to 0 each cycle, then increment the counter.
REQ-016 SHALL move INIT->RUN in the cycle after the counter reaches NREG-1; a full sweep takes exactly NREG cycles and the counter SHALL NOT wrap.
REQ-017 ready SHALL be 0 in INIT and 1 in RUN, registered.
REQ-018 In INIT, SHALL ignore writes and sb_set_en, drive rd_data = 0 and drive rd_busy = 0.
REQ-019 In RUN, a write SHALL update the array at the clk edge when wrN_en=1 and wrN_addr != 0.
REQ-020 When both write ports target the same nonzero address in one cycle, SHALL store wr1_data (port 1 priority).
REQ-021 Reads SHALL be combinational (0-cycle latency) on every port independently.
REQ-022 SHALL forward same-cycle write data: if rd_addr[k] matches an enabled write address, rd_data[k] = that wr_data, with wr1 taking priority over wr0.
REQ-023 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be busy, including under forwarding.
REQ-024 sb_set_en with a nonzero address SHALL set busy[sb_set_addr] at the clk edge.
REQ-025 An enabled write SHALL clear busy[wr_addr] at the clk edge.
REQ-026 When a set and a clear hit the same address in the same cycle, the set SHALL win (a new producer is issued).
REQ-027 rd_busy[k] = busy[rd_addr[k]] AND NOT (an enabled write to rd_addr[k] this cycle); the forwarded value is treated as valid.
REQ-028 An address >= NREG is impossible by construction; no out-of-range handling is required.

Reset
REQ-029 rst_n=0 sampled at a clk edge SHALL force state INIT, counter 0 and ready 0, from either state, including mid-sweep.
REQ-030 Array contents SHALL be cleared only by the INIT sweep, not in a single cycle; busy bits are cleared by the same sweep.
REQ-031 While rst_n=0, SHALL hold rd_data = 0, rd_busy = 0 and ready = 0.
REQ-032 No initial-block file loading SHALL be used; power-up contents are defined solely by reset plus the sweep.

Verification
REQ-033 Release reset with NREG=32 -> ready rises on exactly the 32nd edge after release; reading all addresses returns 0.
REQ-034 In RUN, write x5=0xDEADBEEF on wr0 while reading rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle and in following cycles.
REQ-035 wr0 x7=0x11 and wr1 x7=0x22 in one cycle -> x7 reads 0x22 afterwards; the same-cycle forward also shows 0x22.
REQ-036 Write x0=0xFFFFFFFF with sb_set x0 -> x0 reads 0 and rd_busy=0 on all ports.
REQ-037 sb_set x3; next cycle rd_busy=1 for rd_addr=3; then sb_set x3 together with a wr1 write to x3 in one cycle -> busy stays 1; a later lone write to x3 -> rd_busy drops in the write cycle and stays 0.
REQ-038 Assert rst_n=0 at counter=10 in INIT, then release -> the sweep restarts from 0 and ready rises NREG edges after the release.

Source files
------------

// File: rtl/reg_file_if.sv
// Bus bundle for the multi-ported register file.
//   master : drives write ports, scoreboard set and read addresses;
//            receives read data, busy flags and ready.
//   slave  : the register file itself.
// Member names match the register file's port list so callers see the
// usual wr0_*/wr1_*/rd_*/sb_set_*/ready names.
interface reg_file_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2
);
    localparam int AW = $clog2(NREG);

    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic                ready;

    modport master (
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output rd_addr, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  rd_addr, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-ported register file with a pending-write scoreboard.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : reg_file_if.slave
//           two write ports (wr1 has priority), NRP combinational read
//           ports with same-cycle write forwarding, per-port busy flag,
//           scoreboard set port, ready flag.
// After reset the block sweeps every register (data and busy bit) to zero,
// one per cycle, then enters RUN and raises ready. Register 0 is hardwired
// to read zero and is never busy.
module reg_file_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2
) (
    input logic      clk,
    input logic      rst_n,
    reg_file_if.slave bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Outputs are forced quiet while reset is held, even before the edge
    // that moves the FSM back to INIT.
    logic run;
    assign run = (state_q == ST_RUN) && rst_n;

    // Scoreboard next state: writes retire producers, then a new issue on
    // the same address overrides the retire.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        busy_d = busy_q;
        if (bus.wr0_en) busy_d[bus.wr0_addr] = 1'b0;
        if (bus.wr1_en) busy_d[bus.wr1_addr] = 1'b0;
        if (bus.sb_set_en && bus.sb_set_addr != '0) busy_d[bus.sb_set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the data array has no reset term; the INIT sweep clears it one
    // entry per cycle, which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    mem_q[cnt_q]  <= '0;
                    busy_q[cnt_q] <= 1'b0;
                    // Counter stops at NREG-1 instead of wrapping.
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // wr1 is assigned last so it wins on an address collision.
                    if (bus.wr0_en && bus.wr0_addr != '0) mem_q[bus.wr0_addr] <= bus.wr0_data;
                    if (bus.wr1_en && bus.wr1_addr != '0) mem_q[bus.wr1_addr] <= bus.wr1_data;
                    busy_q <= busy_d;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.ready = ready_q && rst_n;

    // Read ports: combinational, forwarding same-cycle write data (wr1 first).
    logic [AW-1:0]       ra [NRP];
    logic [NRP*XLEN-1:0] rd_data_c;
    logic [NRP-1:0]      rd_busy_c;

    always_comb begin
        for (int k = 0; k < NRP; k++) ra[k] = bus.rd_addr[k*AW +: AW];
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NRP; k++) begin
            if (run && ra[k] != '0) begin
                if (bus.wr1_en && bus.wr1_addr == ra[k]) begin
                    rd_data_c[k*XLEN +: XLEN] = bus.wr1_data;
                end else if (bus.wr0_en && bus.wr0_addr == ra[k]) begin
                    rd_data_c[k*XLEN +: XLEN] = bus.wr0_data;
                end else begin
                    rd_data_c[k*XLEN +: XLEN] = mem_q[ra[k]];
                end
                // A forwarded value is valid, so an in-flight write hides busy.
                rd_busy_c[k] = busy_q[ra[k]]
                             && !(bus.wr0_en && bus.wr0_addr == ra[k])
                             && !(bus.wr1_en && bus.wr1_addr == ra[k]);
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: a behavioural register-file model
// checked every cycle on the falling edge, plus directed literal checks.
module tb_reg_file_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus ();

    reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_known = 1'b0;
    bit              m_run   = 1'b0;
    int              m_swept = 0;
    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_busy [NREG];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_swept = 0;
        end else if (m_known && !m_run) begin
            m_mem[m_swept]  = '0;
            m_busy[m_swept] = 1'b0;
            m_swept++;
            if (m_swept == NREG) m_run = 1'b1;
        end else if (m_known) begin
            if (bus.wr0_en && bus.wr0_addr != 0) m_mem[bus.wr0_addr] = bus.wr0_data;
            if (bus.wr1_en && bus.wr1_addr != 0) m_mem[bus.wr1_addr] = bus.wr1_data;
            if (bus.wr0_en) m_busy[bus.wr0_addr] = 1'b0;
            if (bus.wr1_en) m_busy[bus.wr1_addr] = 1'b0;
            if (bus.sb_set_en && bus.sb_set_addr != 0) m_busy[bus.sb_set_addr] = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_known) begin
            bit live;
            live = m_run && rst_n;
            check("ready", {31'b0, bus.ready}, {31'b0, live});
            for (int k = 0; k < NRP; k++) begin
                logic [AW-1:0]   a;
                logic [XLEN-1:0] ed;
                bit              eb;
                bit              fwd;
                a   = bus.rd_addr[k*AW +: AW];
                ed  = '0;
                eb  = 1'b0;
                fwd = (bus.wr0_en && bus.wr0_addr == a) || (bus.wr1_en && bus.wr1_addr == a);
                if (live && a != 0) begin
                    if (bus.wr1_en && bus.wr1_addr == a)      ed = bus.wr1_data;
                    else if (bus.wr0_en && bus.wr0_addr == a) ed = bus.wr0_data;
                    else                                      ed = m_mem[a];
                    eb = m_busy[a] && !fwd;
                end
                check($sformatf("model rd_data[%0d]", k), bus.rd_data[k*XLEN +: XLEN], ed);
                check($sformatf("model rd_busy[%0d]", k), {31'b0, bus.rd_busy[k]}, {31'b0, eb});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.sb_set_en = 1'b0; bus.sb_set_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    function automatic logic [31:0] rd0();
        return bus.rd_data[0 +: XLEN];
    endfunction

    function automatic logic [31:0] rd1();
        return bus.rd_data[XLEN +: XLEN];
    endfunction

    // Sweep every address two at a time, expecting zero data and no busy.
    task automatic read_all_zero(input string tag);
        for (int a = 0; a < NREG; a += 2) begin
            set_rd(AW'(a), AW'(a + 1));
            @(negedge clk);
            check($sformatf("%s x%0d", tag, a),     rd0(), 32'h0);
            check($sformatf("%s x%0d", tag, a + 1), rd1(), 32'h0);
            check($sformatf("%s busy x%0d/x%0d", tag, a, a + 1), {30'b0, bus.rd_busy}, 32'h0);
            tick();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        idle();
        set_rd('0, '0);
        repeat (3) tick();
        @(negedge clk);
        check("ready in reset", {31'b0, bus.ready}, 32'h0);
        tick();

        // Release: ready must rise on the 32nd edge.
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
        check("sweep edges to ready", n, 32);
        read_all_zero("post-sweep");

        // Write x5 with same-cycle forward on port 0.
        bus.wr0_en = 1'b1; bus.wr0_addr = 5; bus.wr0_data = 32'hDEADBEEF;
        set_rd(5, 0);
        @(negedge clk);
        check("x5 forward", rd0(), 32'hDEADBEEF);
        tick(); idle();
        @(negedge clk);
        check("x5 stored", rd0(), 32'hDEADBEEF);
        tick();

        // Same-address dual write: port 1 wins.
        bus.wr0_en = 1'b1; bus.wr0_addr = 7; bus.wr0_data = 32'h11;
        bus.wr1_en = 1'b1; bus.wr1_addr = 7; bus.wr1_data = 32'h22;
        set_rd(5, 7);
        @(negedge clk);
        check("x7 forward wr1 priority", rd1(), 32'h22);
        tick(); idle();
        @(negedge clk);
        check("x7 stored wr1 priority", rd1(), 32'h22);
        check("x5 unaffected", rd0(), 32'hDEADBEEF);
        tick();

        // x0 is never written nor busy.
        bus.wr0_en = 1'b1; bus.wr0_addr = 0; bus.wr0_data = 32'hFFFFFFFF;
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 0;
        set_rd(0, 0);
        @(negedge clk);
        check("x0 forward blocked", rd0(), 32'h0);
        check("x0 busy same cycle", {30'b0, bus.rd_busy}, 32'h0);
        tick(); idle();
        @(negedge clk);
        check("x0 after write", rd1(), 32'h0);
        check("x0 busy after set", {30'b0, bus.rd_busy}, 32'h0);
        tick();

        // Scoreboard: set x3, set+write x3, then lone write x3.
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 3;
        set_rd(3, 5);
        @(negedge clk);
        check("x3 busy before set edge", {31'b0, bus.rd_busy[0]}, 32'h0);
        tick(); idle();
        @(negedge clk);
        check("x3 busy after set", {31'b0, bus.rd_busy[0]}, 32'h1);
        check("x5 not busy", {31'b0, bus.rd_busy[1]}, 32'h0);
        tick();
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 3;
        bus.wr1_en = 1'b1; bus.wr1_addr = 3; bus.wr1_data = 32'h33;
        @(negedge clk);
        check("x3 busy hidden by forward", {31'b0, bus.rd_busy[0]}, 32'h0);
        check("x3 forward 0x33", rd0(), 32'h33);
        tick(); idle();
        @(negedge clk);
        check("x3 busy set wins", {31'b0, bus.rd_busy[0]}, 32'h1);
        check("x3 stored 0x33", rd0(), 32'h33);
        tick();
        bus.wr0_en = 1'b1; bus.wr0_addr = 3; bus.wr0_data = 32'h44;
        @(negedge clk);
        check("x3 busy drops in write cycle", {31'b0, bus.rd_busy[0]}, 32'h0);
        tick(); idle();
        @(negedge clk);
        check("x3 busy stays clear", {31'b0, bus.rd_busy[0]}, 32'h0);
        check("x3 stored 0x44", rd0(), 32'h44);
        tick();

        // Leave x12 busy, then reset from RUN.
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 12;
        tick(); idle();
        set_rd(5, 12);
        rst_n = 1'b0;
        @(negedge clk);
        check("ready low while rst_n=0", {31'b0, bus.ready}, 32'h0);
        check("rd_data quiet while rst_n=0", rd0(), 32'h0);
        check("rd_busy quiet while rst_n=0", {30'b0, bus.rd_busy}, 32'h0);
        tick(); tick();

        // Start a sweep, abort it at counter=10, release again.
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
            // A write and scoreboard set in INIT must be ignored.
            if (n == 20) begin
                bus.wr0_en = 1'b1; bus.wr0_addr = 9; bus.wr0_data = 32'hCAFEF00D;
                bus.sb_set_en = 1'b1; bus.sb_set_addr = 9;
            end else begin
                idle();
            end
        end
        idle();
        check("restarted sweep edges to ready", n, 32);
        read_all_zero("post-restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
